// File: rtl/lc3_writeback_stage_if.sv
// Writeback-stage bus: result sources, register addresses and the writeback_out group.
// master = upstream driver/observer, slave = the writeback stage itself.
interface lc3_writeback_stage_if #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_ADDR_W = 3
);
   logic                  enable_writeback;
   logic [1:0]            W_Control;
   logic [DATA_WIDTH-1:0] aluout;
   logic [DATA_WIDTH-1:0] memout;
   logic [DATA_WIDTH-1:0] pcout;
   logic [DATA_WIDTH-1:0] npc;
   logic [REG_ADDR_W-1:0] dr;
   logic [REG_ADDR_W-1:0] sr1;
   logic [REG_ADDR_W-1:0] sr2;
   logic                  writeback_enb_out;
   logic [2:0]            psr;
   logic [DATA_WIDTH-1:0] VSR1;
   logic [DATA_WIDTH-1:0] VSR2;

   modport master (
      output enable_writeback, W_Control, aluout, memout, pcout, npc, dr, sr1, sr2,
      input  writeback_enb_out, psr, VSR1, VSR2
   );

   modport slave (
      input  enable_writeback, W_Control, aluout, memout, pcout, npc, dr, sr1, sr2,
      output writeback_enb_out, psr, VSR1, VSR2
   );
endinterface

// File: rtl/lc3_writeback_stage.sv
// LC-3 writeback: result mux into 8-entry RF, NZP update, registered sr1/sr2 reads; 1-clock latency,
// no backpressure (accepts every cycle). Define LC3_WB_BYPASS_EN for write-first same-edge reads.
module lc3_writeback_stage #(
   parameter int         DATA_WIDTH    = 16,
   parameter int         REG_ADDR_W    = 3,
   parameter logic [2:0] PSR_RESET_VAL = 3'b010
) (
   input logic                   clock,
   input logic                   reset,
   lc3_writeback_stage_if.slave  wb
);
   localparam int DEPTH = 1 << REG_ADDR_W;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DATA_WIDTH-1:0] wb_data;
   logic [DATA_WIDTH-1:0] rd1;
   logic [DATA_WIDTH-1:0] rd2;
   logic [DATA_WIDTH-1:0] vsr1_q;
   logic [DATA_WIDTH-1:0] vsr2_q;
   logic [2:0]            psr_q;
   logic                  enb_q;
   logic                  neg;
   logic                  zero;

   always_comb begin
      wb_data = wb.aluout;
      case (wb.W_Control)
         2'd0:    wb_data = wb.aluout;
         2'd1:    wb_data = wb.memout;
         2'd2:    wb_data = wb.pcout;
         default: wb_data = wb.npc;
      endcase
   end

   assign neg  = wb_data[DATA_WIDTH-1];
   assign zero = (wb_data == '0);

`ifdef LC3_WB_BYPASS_EN
   // Write-first: a read of the register being written this edge sees the new value.
   always_comb begin
      rd1 = regs[wb.sr1];
      rd2 = regs[wb.sr2];
      if (wb.enable_writeback && (wb.dr == wb.sr1)) rd1 = wb_data;
      if (wb.enable_writeback && (wb.dr == wb.sr2)) rd2 = wb_data;
   end
`else
   always_comb begin
      rd1 = regs[wb.sr1];
      rd2 = regs[wb.sr2];
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         psr_q  <= PSR_RESET_VAL;
         vsr1_q <= '0;
         vsr2_q <= '0;
         enb_q  <= 1'b0;
      end else begin
         enb_q  <= wb.enable_writeback;
         vsr1_q <= rd1;
         vsr2_q <= rd2;
         if (wb.enable_writeback) begin
            regs[wb.dr] <= wb_data;
            psr_q       <= {neg, zero, !neg && !zero};
         end
      end
   end

   assign wb.writeback_enb_out = enb_q;
   assign wb.psr               = psr_q;
   assign wb.VSR1              = vsr1_q;
   assign wb.VSR2              = vsr2_q;
endmodule

// File: tb/tb_lc3_writeback_stage.sv
// Directed vector table plus hand sequences for reset and mid-stream reset.
module tb_lc3_writeback_stage;
`ifdef LC3_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        en;
      logic [1:0]  wc;
      logic [15:0] alu, mem, pc, npc;
      logic [2:0]  dr, sr1, sr2;
      logic        enb;
      logic [2:0]  psr;
      logic [15:0] v1, v2;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   lc3_writeback_stage_if #(.DATA_WIDTH(16), .REG_ADDR_W(3)) bus ();

   lc3_writeback_stage dut (
      .clock (clock),
      .reset (reset),
      .wb    (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic enb, input logic [2:0] psr,
                             input logic [15:0] v1, input logic [15:0] v2);
      chk({tag, " enb"},  {15'd0, bus.writeback_enb_out}, {15'd0, enb});
      chk({tag, " psr"},  {13'd0, bus.psr}, {13'd0, psr});
      chk({tag, " VSR1"}, bus.VSR1, v1);
      chk({tag, " VSR2"}, bus.VSR2, v2);
   endtask

   task automatic add(input logic en, input logic [1:0] wc, input logic [15:0] alu,
                      input logic [15:0] mem, input logic [15:0] pc, input logic [15:0] npc,
                      input logic [2:0] dr, input logic [2:0] sr1, input logic [2:0] sr2,
                      input logic enb, input logic [2:0] psr, input logic [15:0] v1,
                      input logic [15:0] v2);
      vec_t v;
      v.en = en; v.wc = wc; v.alu = alu; v.mem = mem; v.pc = pc; v.npc = npc;
      v.dr = dr; v.sr1 = sr1; v.sr2 = sr2;
      v.enb = enb; v.psr = psr; v.v1 = v1; v.v2 = v2;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic en, input logic [1:0] wc,
                        input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc,
                        input logic [15:0] npc, input logic [2:0] dr, input logic [2:0] sr1,
                        input logic [2:0] sr2);
      reset = rst;
      bus.enable_writeback = en; bus.W_Control = wc;
      bus.aluout = alu; bus.memout = mem; bus.pcout = pc; bus.npc = npc;
      bus.dr = dr; bus.sr1 = sr1; bus.sr2 = sr2;
   endtask

   initial begin
      //    en wc alu      mem      pc       npc      dr sr1 sr2  enb psr     VSR1                      VSR2
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 3'b010, 16'h0000,                  16'h0000);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 3, 7,  0, 3'b010, 16'h0000,                  16'h0000);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 3'b010, 16'h0000,                  16'h0000);
      add(1, 0, 16'h8001, 16'h0000, 16'h0000, 16'h0000, 3, 0, 0,  1, 3'b100, 16'h0000,                  16'h0000);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 3, 0,  0, 3'b100, 16'h8001,                  16'h0000);
      add(1, 1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 5, 3, 3,  1, 3'b010, 16'h8001,                  16'h8001);
      add(1, 2, 16'h1234, 16'h7777, 16'h3005, 16'h0000, 6, 5, 0,  1, 3'b001, 16'h0000,                  16'h0000);
      add(1, 3, 16'h0000, 16'h0000, 16'h3005, 16'h3001, 7, 6, 5,  1, 3'b001, 16'h3005,                  16'h0000);
      add(0, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 3, 7, 3,  0, 3'b001, 16'h3001,                  16'h8001);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 3, 6,  0, 3'b001, 16'h8001,                  16'h3005);
      add(1, 0, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 2, 0, 0,  1, 3'b001, 16'h0000,                  16'h0000);
      add(1, 0, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 2, 2, 2,  1, 3'b001, BYP ? 16'h2222 : 16'h1111, BYP ? 16'h2222 : 16'h1111);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 2, 2,  0, 3'b001, 16'h2222,                  16'h2222);
      add(1, 0, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0,  1, 3'b001, 16'h0000,                  16'h0000);
      add(1, 0, 16'hFFF0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0,  1, 3'b100, BYP ? 16'hFFF0 : 16'h0005, 16'h0000);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1,  0, 3'b100, 16'hFFF0,                  16'hFFF0);
      add(1, 0, 16'h0ABC, 16'h0000, 16'h0000, 16'h0000, 4, 4, 1,  1, 3'b001, BYP ? 16'h0ABC : 16'h0000, 16'hFFF0);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4, 0,  0, 3'b001, 16'h0ABC,                  16'h0000);

      // Reset with random inputs, including an enabled write that must be dropped.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         @(posedge clock); #1;
         check_outs($sformatf("reset%0d", i), 1'b0, 3'b010, 16'h0000, 16'h0000);
      end

      foreach (vecs[i]) begin
         drive(1'b0, vecs[i].en, vecs[i].wc, vecs[i].alu, vecs[i].mem, vecs[i].pc,
               vecs[i].npc, vecs[i].dr, vecs[i].sr1, vecs[i].sr2);
         @(posedge clock); #1;
         check_outs($sformatf("vec%0d", i), vecs[i].enb, vecs[i].psr, vecs[i].v1, vecs[i].v2);
      end

      // Reset on the same edge as a write of 5555 to R4: nothing retained.
      drive(1'b1, 1'b1, 2'd0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 3'd4, 3'd4, 3'd4);
      @(posedge clock); #1;
      check_outs("midrst", 1'b0, 3'b010, 16'h0000, 16'h0000);
      drive(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd4, 3'd1);
      @(posedge clock); #1;
      check_outs("postrst", 1'b0, 3'b010, 16'h0000, 16'h0000);
      drive(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd7, 3'd2);
      @(posedge clock); #1;
      check_outs("postrst2", 1'b0, 3'b010, 16'h0000, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lc3_writeback_stage.md
Name: lc3_writeback_stage

Overview:
- Writeback stage of the LC-3 pipeline. It drives the writeback_out bus (writeback_enb_out, psr, VSR1, VSR2), so it is the producer of the signals that the writeback_out agent monitors.
- Selects a result from the execute/memory/fetch paths and writes it into an 8-entry general register file.
- Updates the NZP condition codes from the written value.
- Returns registered source-operand reads to the decode/execute stages.

Parameters:
- DATA_WIDTH, 16, width of registers, results and VSR1/VSR2.
- REG_ADDR_W, 3, register address width; register file depth is 2**REG_ADDR_W.
- PSR_RESET_VAL, 3'b010, psr value after reset (Z set, matching all-zero registers).

Ports:
- clock  input  1  stage clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable_writeback  input  1  qualifies a writeback this cycle.
- W_Control  input  2  result select: 0 aluout, 1 memout, 2 pcout, 3 npc.
- aluout  input  DATA_WIDTH  execute result.
- memout  input  DATA_WIDTH  memory load data.
- pcout  input  DATA_WIDTH  computed PC/address result.
- npc  input  DATA_WIDTH  next PC (JSR link value).
- dr  input  REG_ADDR_W  destination register.
- sr1  input  REG_ADDR_W  source register 1 read address.
- sr2  input  REG_ADDR_W  source register 2 read address.
- writeback_enb_out  output  1  registered copy of enable_writeback.
- psr  output  3  condition codes {N,Z,P}.
- VSR1  output  DATA_WIDTH  registered read of R[sr1].
- VSR2  output  DATA_WIDTH  registered read of R[sr2].

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high, sampled on the rising edge of `clock`.
- Reset state:
  - R0..R7 = 0.
  - psr = PSR_RESET_VAL.
  - VSR1 = VSR2 = 0.
  - writeback_enb_out = 0.
  - Reset overrides every other input in the same cycle.
  - A writeback presented in the reset cycle is dropped.
- Result mux: wb_data = aluout / memout / pcout / npc for W_Control = 0 / 1 / 2 / 3. The mux is combinational; no width change.
- Write:
  - On an edge with enable_writeback=1 and reset=0: R[dr] <= wb_data.
  - With enable_writeback=0, the register file is unchanged.
- PSR update, same edge as the write, computed from wb_data:
  - N = wb_data[DATA_WIDTH-1].
  - Z = (wb_data == 0).
  - P = !N && !Z.
  - Exactly one bit is set after any write.
  - psr holds its value when enable_writeback=0.
- Reads:
  - Every cycle, VSR1 <= R[sr1] and VSR2 <= R[sr2]. Latency is 1 clock from the address to the data.
  - Reads are unconditional and do not depend on enable_writeback.
- writeback_enb_out <= enable_writeback every cycle. It is 1 clock delayed and aligned with the psr update.
- Read-during-write (enable_writeback=1, dr == sr1 and/or dr == sr2, same edge):
  - Behaviour is set by the optional feature below.
  - sr1 == sr2 is legal; both outputs then carry identical data.
- Back-to-back writes to the same dr: the last write wins. psr reflects the most recent write only.
- X/unknown on data inputs while enable_writeback=0 must not disturb state.
- Reset mid-stream: state returns to reset values on that edge. No partial write is retained.

Optional Feature:
- Macro: LC3_WB_BYPASS_EN.
- Defined:
  - A same-edge read whose address matches dr while enable_writeback=1 returns wb_data (write-first).
  - The bypass is applied independently to VSR1 and VSR2.
- Undefined:
  - The same read returns the pre-write R contents (read-first).
  - The new value is visible on the following cycle's read.

Test Plan:
- Reset with all inputs random:
  - psr == 3'b010.
  - VSR1 == VSR2 == 0.
  - writeback_enb_out == 0.
  - Held for 3 cycles after reset deasserts with enable_writeback=0.
- Write path:
  - enable_writeback=1, W_Control=0, aluout=16'h8001, dr=3.
  - Next edge: psr == 3'b100, writeback_enb_out == 1.
  - Then sr1=3: VSR1 == 16'h8001 one cycle later.
- Mux and PSR coverage:
  - W_Control=1, memout=16'h0000, dr=5 -> psr == 3'b010.
  - W_Control=2, pcout=16'h3005, dr=6 -> psr == 3'b001.
  - W_Control=3, npc=16'h3001, dr=7 -> R7 == 16'h3001 on readback.
- Hold: enable_writeback=0 with aluout=16'hFFFF, dr=3 -> R3 and psr unchanged; writeback_enb_out == 0.
- Read-during-write:
  - Setup: R2 = 16'h1111. Then enable_writeback=1, aluout=16'h2222, dr=2, sr1=sr2=2.
  - With LC3_WB_BYPASS_EN: VSR1 == VSR2 == 16'h2222.
  - Without it: VSR1 == VSR2 == 16'h1111, then 16'h2222 on the next cycle.
- Reset mid-operation: assert reset in the same cycle as a write of 16'h5555 to R4 -> R4 == 0 and psr == 3'b010 afterwards.
